// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-in/parallel-out deserialiser.
package sipo_pkg;

  typedef enum logic [0:0] {
    SIPO_COLLECT = 1'b0,
    SIPO_PARITY  = 1'b1
  } sipo_state_e;

  // Width of a counter able to hold the value w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit-position counter for sipo_deser: counts enabled cycles up to a terminal value,
// wraps to zero after it and strobes last_bit_c on the terminal cycle.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          PARITY_SLOT = 1'b0,
  localparam int unsigned CNT_W      = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             last_bit_c
);

  // With a parity slot the counter parks at WIDTH for one extra bit.
  localparam int unsigned LAST = PARITY_SLOT ? WIDTH : WIDTH - 1;

  logic at_last;

  assign at_last    = (count == CNT_W'(LAST));
  assign last_bit_c = en && !clear && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= at_last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with valid/ready holding register.
// Optional parity slot after each word when SIPO_PARITY_CHECK_EN is defined.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned ODD_PARITY = 0,
  localparam int unsigned CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             parity_err
);

  if (WIDTH < 2 || WIDTH > 32 || LSB_FIRST > 1 || ODD_PARITY > 1) begin : g_param_check
    $error("sipo_deser: illegal parameter value");
  end

`ifdef SIPO_PARITY_CHECK_EN
  localparam bit          HAS_PARITY = 1'b1;
  localparam int unsigned SR_W       = WIDTH;
`else
  // Without parity the last bit goes straight to the holding register, so it is never stored.
  localparam bit          HAS_PARITY = 1'b0;
  localparam int unsigned SR_W       = WIDTH - 1;
`endif

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_shift_c;
  logic [WIDTH-1:0] word_c;
  logic             word_done_c;

  sipo_bit_counter #(
    .WIDTH       (WIDTH),
    .PARITY_SLOT (HAS_PARITY)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (shift_en),
    .clear      (clear),
    .count      (bit_count),
    .last_bit_c (word_done_c)
  );

  // Shift direction and the word assembled on the completing edge.
  if (LSB_FIRST != 0) begin : g_lsb
    if (SR_W == 1) begin : g_one
      assign sr_shift_c = serial_in;
    end else begin : g_many
      assign sr_shift_c = {serial_in, sr[SR_W-1:1]};
    end
`ifndef SIPO_PARITY_CHECK_EN
    assign word_c = {serial_in, sr};
`endif
  end else begin : g_msb
    if (SR_W == 1) begin : g_one
      assign sr_shift_c = serial_in;
    end else begin : g_many
      assign sr_shift_c = {sr[SR_W-2:0], serial_in};
    end
`ifndef SIPO_PARITY_CHECK_EN
    assign word_c = {sr, serial_in};
`endif
  end

`ifdef SIPO_PARITY_CHECK_EN
  sipo_state_e state;
  logic        perr_c;

  assign word_c = sr;
  assign perr_c = (^sr ^ serial_in) != 1'(ODD_PARITY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SIPO_COLLECT;
      sr         <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clear) begin
        state   <= SIPO_COLLECT;
        sr      <= '0;
        overrun <= 1'b0;
      end else if (shift_en) begin
        if (state == SIPO_COLLECT) begin
          sr <= sr_shift_c;
          if (bit_count == CNT_W'(WIDTH - 1)) state <= SIPO_PARITY;
        end else begin
          state <= SIPO_COLLECT;
        end
      end
      // Holding register: load when empty or draining this edge, otherwise drop and flag.
      if (word_done_c) begin
        if (!out_valid || out_ready) begin
          out_data   <= word_c;
          parity_err <= perr_c;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign parity_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clear) begin
        sr      <= '0;
        overrun <= 1'b0;
      end else if (shift_en) begin
        sr <= sr_shift_c;
      end
      // Holding register: load when empty or draining this edge, otherwise drop and flag.
      if (word_done_c) begin
        if (!out_valid || out_ready) begin
          out_data  <= word_c;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
